// File: rtl/gate_arb_pkg.sv
// -----------------------------------------------------------------------------
// gate_arb_pkg
// Shared types for the gate unit and its round-robin arbiter.
//   gate_op_t   : bitwise opcode carried on each requester's op slice
//   arb_state_t : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package gate_arb_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } gate_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : gate_arb_pkg

// File: rtl/gate_unit.sv
// -----------------------------------------------------------------------------
// gate_unit
// Purely combinational bitwise gate over WIDTH bits.
// Ports:
//   op : gate_op_t opcode (AND / OR / XOR / XNOR)
//   a  : operand A
//   b  : operand B
//   y  : result, same width as the operands (no carries involved)
// -----------------------------------------------------------------------------
module gate_unit
    import gate_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  gate_op_t           op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y
);

    // Opcode decode into the selected bitwise function
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule : gate_unit

// File: rtl/gate_unit_arbiter.sv
// -----------------------------------------------------------------------------
// gate_unit_arbiter
// Shares one registered gate unit among N_REQ requesters using round-robin
// arbitration. One operation is in flight at a time: IDLE grants and latches
// operands, EXEC registers the result, RESP presents it until accepted.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   req_valid    : per-requester request valid            [N_REQ]
//   req_ready    : per-requester accept, one-hot or zero   [N_REQ]
//   req_op       : per-requester opcode, slice i = [2i+1:2i]
//   req_a/req_b  : per-requester operands, slice i = [WIDTH*i +: WIDTH]
//   resp_valid   : result available
//   resp_ready   : consumer accepts result
//   resp_id      : requester index owning resp_y
//   resp_y       : result
//   busy         : high while an operation is in EXEC or RESP
// -----------------------------------------------------------------------------
module gate_unit_arbiter
    import gate_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [WIDTH*N_REQ-1:0]   req_a,
    input  logic [WIDTH*N_REQ-1:0]   req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_y,
    output logic                     busy
);

    // Round-robin pick: search from last+1 upward with wrap; the first valid
    // requester wins. Returns {found, index}. Walking the offsets from the
    // farthest to the nearest lets the nearest hit overwrite earlier ones.
    function automatic logic [ID_W:0] rr_pick(
        input logic [N_REQ-1:0] valid,
        input logic [ID_W-1:0]  last
    );
        logic [ID_W:0] result;
        int            idx;
        result = {(ID_W+1){1'b0}};
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (valid[idx]) begin
                result = {1'b1, idx[ID_W-1:0]};
            end
        end
        return result;
    endfunction

    arb_state_t          state_r;
    logic [ID_W-1:0]     last_grant_r;
    logic [ID_W-1:0]     id_r;
    gate_op_t            op_r;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;

    logic [ID_W:0]       pick_s;
    logic                pick_found_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic [1:0]          sel_op_s;
    logic [WIDTH-1:0]    sel_a_s;
    logic [WIDTH-1:0]    sel_b_s;
    logic [WIDTH-1:0]    gate_y_s;
    logic                grant_s;

    assign pick_s       = rr_pick(req_valid, last_grant_r);
    assign pick_found_s = pick_s[ID_W];
    assign pick_idx_s   = pick_s[ID_W-1:0];

    // A grant is only offered in IDLE and never while reset is asserted, so
    // the pick always lands on a valid requester and a grant is a handshake.
    assign grant_s = (state_r == IDLE) && pick_found_s && !rst;

    // Winner's operand mux, built as an AND-OR so exactly one slice passes
    always_comb begin
        sel_op_s = 2'b00;
        sel_a_s  = {WIDTH{1'b0}};
        sel_b_s  = {WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_op_s = sel_op_s | (req_op[2*i +: 2]         & {2{ID_W'(i) == pick_idx_s}});
            sel_a_s  = sel_a_s  | (req_a[WIDTH*i +: WIDTH] & {WIDTH{ID_W'(i) == pick_idx_s}});
            sel_b_s  = sel_b_s  | (req_b[WIDTH*i +: WIDTH] & {WIDTH{ID_W'(i) == pick_idx_s}});
        end
    end

    // Combinational one-hot accept toward the winning requester
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        if (grant_s) begin
            req_ready[pick_idx_s] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Shared gate datapath operating on the latched operands
    gate_unit #(
        .WIDTH (WIDTH)
    ) u_gate_unit (
        .op (op_r),
        .a  (a_r),
        .b  (b_r),
        .y  (gate_y_s)
    );

    // Arbiter FSM: operand latch, result register and response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= ID_W'(N_REQ - 1);
            id_r         <= {ID_W{1'b0}};
            op_r         <= OP_AND;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            resp_valid   <= 1'b0;
            resp_id      <= {ID_W{1'b0}};
            resp_y       <= {WIDTH{1'b0}};
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        op_r    <= gate_op_t'(sel_op_s);
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        id_r    <= pick_idx_s;
                        busy    <= 1'b1;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    resp_y     <= gate_y_s;
                    resp_id    <= id_r;
                    resp_valid <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    // Without resp_ready everything stays frozen
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        busy         <= 1'b0;
                        last_grant_r <= resp_id;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule : gate_unit_arbiter

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_y;
    logic             busy;

    int tests  = 0;
    int errors = 0;

    // Reference model state: one outstanding job with an age
    int          m_last;
    bit          m_job;
    int          m_stage;   // 0: being computed, 1: result on offer
    int          m_id;
    logic [7:0]  m_y;

    gate_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_gate(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_ready;
        int g;
        exp_ready = 4'b0000;
        if (!rst && !m_job) begin
            g = model_pick(req_valid, m_last);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
        chk("busy", {31'd0, busy}, {31'd0, m_job});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, (m_job && m_stage == 1)});
        if (m_job && m_stage == 1) begin
            chk("resp_id", {30'd0, resp_id}, m_id);
            chk("resp_y", {24'd0, resp_y}, {24'd0, m_y});
        end
    endtask

    task automatic model_update();
        int g;
        if (rst) begin
            m_job = 1'b0; m_stage = 0; m_last = N - 1;
        end else if (!m_job) begin
            g = model_pick(req_valid, m_last);
            if (g >= 0) begin
                m_job = 1'b1; m_stage = 0; m_id = g;
                m_y = model_gate(req_op[2*g +: 2], req_a[W*g +: W], req_b[W*g +: W]);
            end
        end else if (m_stage == 0) begin
            m_stage = 1;
        end else if (resp_ready) begin
            m_job = 1'b0; m_last = m_id;
        end
    endtask

    // One cycle: settle, check against model, clock, advance model
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int          grants[8];
    logic [7:0]  ys[8];
    int          ng, ny, g;
    logic [1:0]  cap_id;
    logic [7:0]  cap_y;

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        m_job = 1'b0; m_stage = 0; m_last = N - 1; m_id = 0; m_y = 8'h00;
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b1111;
        do_reset();
        req_valid = 4'b0000;

        // Reset values
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
        chk("rst_resp_y", {24'd0, resp_y}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Idle: nothing requested for 10 cycles
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_ready", {28'd0, req_ready}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_rv", {31'd0, resp_valid}, 32'd0);
            step();
        end

        // Single requester 2, XOR F0 ^ 3C
        req_valid = 4'b0100; req_op = 8'b00_10_00_00;
        req_a = 32'h00F0_0000; req_b = 32'h003C_0000;
        #1;
        chk("t1_ready", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        chk("t1_exec_rv", {31'd0, resp_valid}, 32'd0);
        chk("t1_exec_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_rv", {31'd0, resp_valid}, 32'd1);
        chk("t1_id", {30'd0, resp_id}, 32'd2);
        chk("t1_y", {24'd0, resp_y}, 32'hCC);
        resp_ready = 1'b1;
        step();

        // All four valid after reset: grants 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111; req_op = 8'b11_10_01_00;
        req_a = 32'hAAAA_AAAA; req_b = 32'h0F0F_0F0F; resp_ready = 1'b1;
        ng = 0; ny = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            g = onehot_idx(req_ready);
            if (g >= 0 && ng < 8) begin grants[ng] = g; ng++; end
            if (resp_valid && resp_ready && ny < 8) begin ys[ny] = resp_y; ny++; end
            step();
        end
        chk("rr_ngrants", ng, 32'd5);
        chk("rr_nresp", ny, 32'd5);
        if (ng >= 5) begin
            chk("rr_g0", grants[0], 32'd0); chk("rr_g1", grants[1], 32'd1);
            chk("rr_g2", grants[2], 32'd2); chk("rr_g3", grants[3], 32'd3);
            chk("rr_g4", grants[4], 32'd0);
        end
        if (ny >= 5) begin
            chk("rr_y0", {24'd0, ys[0]}, 32'h0A); chk("rr_y1", {24'd0, ys[1]}, 32'hAF);
            chk("rr_y2", {24'd0, ys[2]}, 32'hA5); chk("rr_y3", {24'd0, ys[3]}, 32'h5A);
            chk("rr_y4", {24'd0, ys[4]}, 32'h0A);
        end

        // Back-pressure: requester 1 (OR) held in RESP for 5 cycles
        resp_ready = 1'b0;
        step();
        step();
        cap_id = resp_id; cap_y = resp_y;
        chk("bp_id", {30'd0, cap_id}, 32'd1);
        chk("bp_y", {24'd0, cap_y}, 32'hAF);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rv", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_id", {30'd0, resp_id}, {30'd0, cap_id});
            chk("bp_hold_y", {24'd0, resp_y}, {24'd0, cap_y});
            chk("bp_ready", {28'd0, req_ready}, 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        chk("bp_release_rv", {31'd0, resp_valid}, 32'd0);
        chk("bp_release_busy", {31'd0, busy}, 32'd0);

        // Pointer wrap: serve 3, then 1 beats 3, then 3
        do_reset();
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) step();
        req_valid = 4'b1010;
        #1;
        chk("wrap_first", {28'd0, req_ready}, 32'h2);
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("wrap_second", {28'd0, req_ready}, 32'h8);
        for (int i = 0; i < 3; i++) step();

        // Reset in EXEC discards the operation
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        rst = 1'b1;
        chk("mid_rst_rv", {31'd0, resp_valid}, 32'd0);
        step();
        rst = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("mid_rst_after_rv", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_grant0", {28'd0, req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_op     = 8'($urandom);
            req_a      = $urandom;
            req_b      = $urandom;
            resp_ready = ($urandom_range(0, 9) < 7);
            rst        = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule : tb_gate_unit_arbiter
